// File: rtl/bios_arb_if.sv
// Bus bundle between the two BIOS ROM requesters, the ROM read port and bios_read_arbiter.
// slave = arbiter side; master = environment side (requesters plus ROM).
interface bios_arb_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
);
  logic [1:0]        req_valid;
  logic [AWIDTH-1:0] req_addr0;
  logic [AWIDTH-1:0] req_addr1;
  logic [1:0]        req_ready;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [DWIDTH-1:0] resp_data;
  logic              mem_en;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_dout;

  modport slave (
    input  req_valid, req_addr0, req_addr1, resp_ready, mem_dout,
    output req_ready, resp_valid, resp_data, mem_en, mem_addr
  );

  modport master (
    output req_valid, req_addr0, req_addr1, resp_ready, mem_dout,
    input  req_ready, resp_valid, resp_data, mem_en, mem_addr
  );
endinterface

// File: rtl/bios_read_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency BIOS ROM read port between two requesters.
// Optional BIOS_ARB_STATS_EN adds per-port grant counters and a HOLD-cycle stall counter.
module bios_read_arbiter #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  bios_arb_if.slave       bus
`ifdef BIOS_ARB_STATS_EN
  ,
  output logic [31:0]     grant_cnt0,
  output logic [31:0]     grant_cnt1,
  output logic [31:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [DWIDTH-1:0] hold_q, hold_d;

  logic any_req;
  logic winner;
  logic owner_done;
  logic can_grant;
  logic accept;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;

    any_req    = |bus.req_valid;
    winner     = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    owner_done = bus.resp_ready[owner_q];

    unique case (state_q)
      IDLE:       can_grant = 1'b1;
      READ, HOLD: can_grant = owner_done;
      default:    can_grant = 1'b0;
    endcase
    accept = can_grant && any_req && !rst;

    if (accept) begin
      owner_d      = winner;
      last_grant_d = winner;
    end

    unique case (state_q)
      IDLE: if (accept) state_d = READ;
      READ: begin
        // Always capture ROM data so resp_data keeps its last value once the response retires.
        hold_d = bus.mem_dout;
        if (owner_done) state_d = accept ? READ : IDLE;
        else            state_d = HOLD;
      end
      HOLD: if (owner_done) state_d = accept ? READ : IDLE;
      default: state_d = IDLE;
    endcase

    bus.req_ready = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
    bus.mem_en    = accept;
    bus.mem_addr  = accept ? (winner ? bus.req_addr1 : bus.req_addr0) : '0;

    bus.resp_valid = 2'b00;
    if (!rst && (state_q == READ || state_q == HOLD))
      bus.resp_valid = owner_q ? 2'b10 : 2'b01;

    if (rst)                  bus.resp_data = '0;
    else if (state_q == READ) bus.resp_data = bus.mem_dout;
    else                      bus.resp_data = hold_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
    end
  end

`ifdef BIOS_ARB_STATS_EN
  logic [31:0] grant_cnt0_q, grant_cnt0_d;
  logic [31:0] grant_cnt1_q, grant_cnt1_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt0_d = grant_cnt0_q + {31'd0, accept && !winner};
    grant_cnt1_d = grant_cnt1_q + {31'd0, accept && winner};
    stall_cnt_d  = stall_cnt_q + {31'd0, state_q == HOLD};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bios_read_arbiter.sv
// Scoreboard bench for bios_read_arbiter: stimulus pushes expected responses, a monitor pops
// and compares them on every response handshake.
module tb_bios_read_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bios_arb_if #(.AWIDTH(AW), .DWIDTH(DW)) bif();

`ifdef BIOS_ARB_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  bios_read_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
`ifdef BIOS_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_gnt0 = 0;
  int exp_gnt1 = 0;
  int exp_stall = 0;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a ^ 12'hA5C, 8'h3C, a};
  endfunction

  function automatic logic [1:0] oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  // ROM model: enable-gated, one-cycle read latency.
  always @(posedge clk) begin
    if (rst)              bif.mem_dout <= '0;
    else if (bif.mem_en)  bif.mem_dout <= rom_word(bif.mem_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_chk(input string tag, input logic p, input logic [AW-1:0] a);
    resp_t r;
    check({tag, "_req_ready"}, 64'(bif.req_ready), 64'(oh(p)));
    check({tag, "_mem_en"},    64'(bif.mem_en),    64'd1);
    check({tag, "_mem_addr"},  64'(bif.mem_addr),  64'(a));
    r.port = p;
    r.data = rom_word(a);
    exp_q.push_back(r);
    if (p) exp_gnt1++;
    else   exp_gnt0++;
  endtask

  task automatic no_grant(input string tag);
    check({tag, "_req_ready"}, 64'(bif.req_ready), 64'd0);
    check({tag, "_mem_en"},    64'(bif.mem_en),    64'd0);
  endtask

  // Monitor: every completed response handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (bif.resp_valid[i] && bif.resp_ready[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: port %0d responded with data 0x%0h, expected no response", i, bif.resp_data);
          end else begin
            resp_t e;
            e = exp_q.pop_front();
            check("resp_port", 64'(i), 64'(e.port));
            check("resp_data", 64'(bif.resp_data), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] a0, a1;
    logic p;

    rst = 1'b1;
    bif.req_valid  = 2'b11;
    bif.req_addr0  = 12'h0AA;
    bif.req_addr1  = 12'h0BB;
    bif.resp_ready = 2'b00;
    cycle();
    @(negedge clk);
    check("rst_req_ready",  64'(bif.req_ready),  64'd0);
    check("rst_resp_valid", 64'(bif.resp_valid), 64'd0);
    check("rst_mem_en",     64'(bif.mem_en),     64'd0);
    check("rst_mem_addr",   64'(bif.mem_addr),   64'd0);
    check("rst_resp_data",  64'(bif.resp_data),  64'd0);
    cycle();
    rst = 1'b0;

    // Contention from reset: grants alternate 0,1,0,1 at one per cycle.
    a0 = 12'h100;
    a1 = 12'h200;
    bif.resp_ready = 2'b11;
    bif.req_valid  = 2'b11;
    bif.req_addr0  = a0;
    bif.req_addr1  = a1;
    for (int k = 0; k < 4; k++) begin
      p = k[0];
      @(negedge clk);
      grant_chk("rr", p, p ? a1 : a0);
      if (k > 0) check("rr_resp_valid", 64'(bif.resp_valid), 64'(oh(~p)));
      cycle();
      if (p) begin a1 = a1 + 12'd1; bif.req_addr1 = a1; end
      else   begin a0 = a0 + 12'd1; bif.req_addr0 = a0; end
    end
    bif.req_valid = 2'b00;
    @(negedge clk);
    no_grant("rr_tail");
    check("rr_tail_resp_valid", 64'(bif.resp_valid), 64'd2);
    cycle();
    @(negedge clk);
    check("rr_idle_resp_valid", 64'(bif.resp_valid), 64'd0);
    cycle();

    // Single read on port 0.
    bif.req_valid = 2'b01;
    bif.req_addr0 = 12'h010;
    @(negedge clk);
    grant_chk("single", 1'b0, 12'h010);
    cycle();
    bif.req_valid = 2'b00;
    @(negedge clk);
    check("single_resp_valid", 64'(bif.resp_valid), 64'd1);
    check("single_resp_data",  64'(bif.resp_data),  64'(rom_word(12'h010)));
    no_grant("single_read");
    cycle();
    @(negedge clk);
    check("single_idle_valid", 64'(bif.resp_valid), 64'd0);
    check("single_idle_data",  64'(bif.resp_data),  64'(rom_word(12'h010)));
    cycle();

    // Stall on port 1 at the top address while port 0 waits.
    bif.req_valid  = 2'b10;
    bif.req_addr1  = 12'hFFF;
    bif.resp_ready = 2'b00;
    @(negedge clk);
    grant_chk("stall", 1'b1, 12'hFFF);
    cycle();
    bif.req_valid = 2'b01;
    bif.req_addr0 = 12'h020;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_resp_valid", 64'(bif.resp_valid), 64'd2);
      check("stall_resp_data",  64'(bif.resp_data),  64'(rom_word(12'hFFF)));
      no_grant("stall_blocked");
      if (s > 0) exp_stall++;
      cycle();
    end
    bif.resp_ready = 2'b10;
    @(negedge clk);
    check("release_resp_data", 64'(bif.resp_data), 64'(rom_word(12'hFFF)));
    grant_chk("release", 1'b0, 12'h020);
    exp_stall++;
    cycle();
    bif.req_valid  = 2'b00;
    bif.resp_ready = 2'b11;
    @(negedge clk);
    check("release_next_valid", 64'(bif.resp_valid), 64'd1);
    cycle();
    @(negedge clk);
    check("release_idle_valid", 64'(bif.resp_valid), 64'd0);
    cycle();

    // Owner 0 stalled while non-owner port 1 signals ready.
    bif.req_valid  = 2'b01;
    bif.req_addr0  = 12'h030;
    bif.resp_ready = 2'b10;
    @(negedge clk);
    grant_chk("nonowner", 1'b0, 12'h030);
    cycle();
    bif.req_valid = 2'b00;
    @(negedge clk);
    check("nonowner_read_valid", 64'(bif.resp_valid), 64'd1);
    cycle();
    @(negedge clk);
    check("nonowner_hold_valid", 64'(bif.resp_valid), 64'd1);
    check("nonowner_hold_data",  64'(bif.resp_data),  64'(rom_word(12'h030)));
    exp_stall++;
    cycle();
    bif.resp_ready = 2'b01;
    @(negedge clk);
    check("nonowner_release_valid", 64'(bif.resp_valid), 64'd1);
    exp_stall++;
    cycle();
    @(negedge clk);
    check("nonowner_idle_valid", 64'(bif.resp_valid), 64'd0);
`ifdef BIOS_ARB_STATS_EN
    check("stats_grant_cnt0", 64'(grant_cnt0), 64'(exp_gnt0));
    check("stats_grant_cnt1", 64'(grant_cnt1), 64'(exp_gnt1));
    check("stats_stall_cnt",  64'(stall_cnt),  64'(exp_stall));
`endif
    cycle();

    // Reset while holding a port 1 response: response discarded, round-robin restarts at port 0.
    bif.req_valid  = 2'b10;
    bif.req_addr1  = 12'h040;
    bif.resp_ready = 2'b00;
    @(negedge clk);
    check("hold_rst_req_ready", 64'(bif.req_ready), 64'd2);
    cycle();
    bif.req_valid = 2'b00;
    @(negedge clk);
    check("hold_rst_read_valid", 64'(bif.resp_valid), 64'd2);
    cycle();
    @(negedge clk);
    check("hold_rst_hold_valid", 64'(bif.resp_valid), 64'd2);
    cycle();
    rst = 1'b1;
    @(negedge clk);
    check("in_rst_resp_valid", 64'(bif.resp_valid), 64'd0);
    cycle();
    rst = 1'b0;
    bif.resp_ready = 2'b11;
    @(negedge clk);
    check("post_rst_resp_valid", 64'(bif.resp_valid), 64'd0);
    check("post_rst_resp_data",  64'(bif.resp_data),  64'd0);
`ifdef BIOS_ARB_STATS_EN
    check("post_rst_grant_cnt0", 64'(grant_cnt0), 64'd0);
    check("post_rst_grant_cnt1", 64'(grant_cnt1), 64'd0);
    check("post_rst_stall_cnt",  64'(stall_cnt),  64'd0);
`endif
    cycle();
    bif.req_valid = 2'b11;
    bif.req_addr0 = 12'h050;
    bif.req_addr1 = 12'h060;
    @(negedge clk);
    grant_chk("post_rst_first", 1'b0, 12'h050);
    cycle();
    bif.req_valid = 2'b10;
    @(negedge clk);
    grant_chk("post_rst_second", 1'b1, 12'h060);
    cycle();
    bif.req_valid = 2'b00;
    @(negedge clk);
    check("post_rst_tail_valid", 64'(bif.resp_valid), 64'd2);
    cycle();
    @(negedge clk);
    check("final_idle_valid", 64'(bif.resp_valid), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
